// File: rtl/ha_array_accum_if.sv
// Handshake and row bus between the half-adder array stage and its serial accumulator.
// The master side drives operands and out_ready. The slave side returns in_ready and the product.
interface ha_array_accum_if #(
   parameter int OUT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [8:0]       ha_array_0_t;
   logic [8:0]       ha_array_1_t;
   logic [8:0]       ha_array_2_t;
   logic [8:0]       ha_array_3_t;
   logic [6:0]       ha_array_0_b;
   logic [6:0]       ha_array_1_b;
   logic [6:0]       ha_array_2_b;
   logic [6:0]       ha_array_3_b;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] product;
   logic             ovf;

   modport master (
      output in_valid, out_ready,
      output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
      output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
      input  in_ready, out_valid, product, ovf
   );

   modport slave (
      input  in_valid, out_ready,
      input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
      input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
      output in_ready, out_valid, product, ovf
   );
endinterface

// File: rtl/ha_array_accum.sv
// Serial accumulator for the four half-adder arrays of the approximate 8x8 multiplier.
// A single shared adder folds in one array per cycle, and the result saturates to OUT_W bits.
//
// state | meaning
// IDLE  | ready for an operand set; accept latches all rows and clears acc
// ACC   | add term[idx] each cycle; the add for idx=3 moves to DONE
// DONE  | product/ovf valid and held until out_ready
module ha_array_accum #(
   parameter int ACC_W = 17,
   parameter int OUT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   ha_array_accum_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

   state_t           state, state_nxt;
   logic [3:0][8:0]  t_q;
   logic [3:0][6:0]  b_q;
   logic [ACC_W-1:0] acc, acc_sum, row, term;
   logic [1:0]       idx;
   logic [OUT_W-1:0] product_q;
   logic             ovf_q;
   logic             in_ready, accept;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (bus.in_valid && !rst) state_nxt = ACC;
         end
         ACC:  if (idx == 2'd3) state_nxt = DONE;
         DONE: if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = in_ready && bus.in_valid;

   // Array k carries weight 4^k, and its b row sits two bits above its t row.
   always_comb begin
      row     = ACC_W'(t_q[idx]) + (ACC_W'(b_q[idx]) << 2);
      term    = row << {idx, 1'b0};
      acc_sum = acc + term;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         idx       <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         t_q <= {bus.ha_array_3_t, bus.ha_array_2_t, bus.ha_array_1_t, bus.ha_array_0_t};
         b_q <= {bus.ha_array_3_b, bus.ha_array_2_b, bus.ha_array_1_b, bus.ha_array_0_b};
         acc <= '0;
         idx <= '0;
      end else if (state == ACC) begin
         acc <= acc_sum;
         // idx parks at 3 and is reloaded only by the next accept.
         if (idx != 2'd3) idx <= idx + 2'd1;
         if (idx == 2'd3) begin
            ovf_q     <= (acc_sum > SAT_MAX);
            product_q <= (acc_sum > SAT_MAX) ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == DONE);
   assign bus.product   = product_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_ha_array_accum.sv
// Bench for ha_array_accum. It uses directed and random operand sets, checks them against an
// arithmetic model, and also covers backpressure and reset in the middle of an operation.
module tb_ha_array_accum;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ha_array_accum_if #(.OUT_W(16)) bus ();

   ha_array_accum #(.ACC_W(17), .OUT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [3:0][8:0] t, input logic [3:0][6:0] b,
                                 output int prod, output int ov);
      int sum = 0;
      for (int k = 0; k < 4; k++) sum += (int'(t[k]) + 4 * int'(b[k])) * (1 << (2 * k));
      ov   = (sum > 65535) ? 1 : 0;
      prod = ov ? 65535 : sum;
   endfunction

   task automatic drive_rows(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
      bus.ha_array_0_t = t[0]; bus.ha_array_1_t = t[1];
      bus.ha_array_2_t = t[2]; bus.ha_array_3_t = t[3];
      bus.ha_array_0_b = b[0]; bus.ha_array_1_b = b[1];
      bus.ha_array_2_b = b[2]; bus.ha_array_3_b = b[3];
   endtask

   task automatic scramble_rows();
      logic [3:0][8:0] t;
      logic [3:0][6:0] b;
      for (int k = 0; k < 4; k++) begin
         t[k] = 9'($urandom);
         b[k] = 7'($urandom);
      end
      drive_rows(t, b);
   endtask

   // Sends one set, holds out_ready low for 'hold' cycles with noise on the inputs, then drains it.
   task automatic send(input logic [3:0][8:0] t, input logic [3:0][6:0] b, input int hold);
      int n;
      int exp_p, exp_o;
      model(t, b, exp_p, exp_o);
      @(negedge clk);
      drive_rows(t, b);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      scramble_rows();
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!bus.out_valid && n < 20);
      check("latency", 32'(n), 32'd4);
      check("product", 32'(bus.product), 32'(exp_p));
      check("ovf", 32'(bus.ovf), 32'(exp_o));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'($urandom);
         scramble_rows();
         @(posedge clk);
         @(negedge clk);
         check("hold_product", 32'(bus.product), 32'(exp_p));
         check("hold_ovf", 32'(bus.ovf), 32'(exp_o));
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("drain_valid", 32'(bus.out_valid), 32'd0);
      check("drain_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      logic [3:0][8:0] t;
      logic [3:0][6:0] b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      t = '0; b = '0;
      t[0] = 9'h1FF;
      drive_rows(t, b);

      // An operand set offered while rst is high must be ignored.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_product", 32'(bus.product), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("post_rst_idle_valid", 32'(bus.out_valid), 32'd0);
         check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      end

      t = '0; b = '0;
      send(t, b, 0);
      t[0] = 9'h001;
      send(t, b, 0);
      t = '0; b[3] = 7'h7F;
      send(t, b, 1);
      t = '0; b = '0; t[1] = 9'h0FF; b[2] = 7'h01;
      send(t, b, 0);
      for (int k = 0; k < 4; k++) begin
         t[k] = 9'h1FF;
         b[k] = 7'h7F;
      end
      send(t, b, 0);
      t = '0; b = '0;
      send(t, b, 0);
      t[2] = 9'h123; b[1] = 7'h55;
      send(t, b, 10);

      // Reset lands on the second ACC cycle and discards the partial sum.
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         t[k] = 9'h1FF;
         b[k] = 7'h7F;
      end
      drive_rows(t, b);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_product", 32'(bus.product), 32'd0);
      repeat (6) begin
         @(negedge clk);
         check("abort_no_pulse", 32'(bus.out_valid), 32'd0);
      end
      t = '0; b = '0; t[3] = 9'h002; b[0] = 7'h03;
      send(t, b, 0);

      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < 4; k++) begin
            t[k] = 9'($urandom);
            b[k] = 7'($urandom);
         end
         send(t, b, int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
